// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_conditioner                                                         |
// | Synchronises and debounces raw push-buttons; emits clean levels plus       |
// | one-cycle press/release pulses. Optional long-press: BUTTON_LONG_PRESS_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module button_conditioner #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [NUM_BUTTONS-1:0] button_long
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BUTTON_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 1);
`else
  logic [31:0] w_unused_long_cycles;
  assign w_unused_long_cycles = LONG_PRESS_CYCLES;
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    logic             sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        state_q   <= RELEASED;
        count_q   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= button_raw[g];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        count_q   <= count_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // The count tracks consecutive samples that disagree with the accepted level.
    always_comb begin
      state_d   = state_q;
      count_d   = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (sync2_q) begin
            state_d = PRESS_WAIT;
            count_d = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_d = RELEASED;
          end else if (count_q == CNT_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_d = RELEASE_WAIT;
            count_d = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q) begin
            state_d = PRESSED;
          end else if (count_q == CNT_LAST) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    assign button_level[g]   = level_q;
    assign button_press[g]   = press_q;
    assign button_release[g] = release_q;

`ifdef BUTTON_LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    // Saturating at HOLD_LAST gives exactly one pulse per press.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PRESS_WAIT && state_d == PRESSED) begin
        hold_d = '0;
      end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_q == HOLD_PRE);
      end
    end

    assign button_long[g] = long_q;
`else
    assign button_long[g] = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// Testbench for button_conditioner: directed scenarios plus a randomized run
// compared cycle by cycle against a "consecutive disagreeing samples" model.
module tb_button_conditioner;
  localparam int N   = 2;
  localparam int D   = 4;
  localparam int L   = 20;
  localparam int LAT = D + 2;  // ticks from raw change (tick 1 = edge E0) to visible output

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clock      = 1'b0;
  logic         reset_n    = 1'b0;
  logic [N-1:0] button_raw = '0;
  logic [N-1:0] button_level, button_press, button_release, button_long;
  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .NUM_BUTTONS      (N),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .button_long   (button_long)
  );

  always #5 clock = ~clock;

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for D consecutive clocks; long fires L clocks after a press.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release, m_long;
  int m_run  [N];
  int m_hold [N];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0; m_long = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        m_press[c] = 1'b0; m_release[c] = 1'b0; m_long[c] = 1'b0;
        if (LONG_EN && m_level[c] && m_hold[c] < L) begin
          m_hold[c]++;
          if (m_hold[c] == L) m_long[c] = 1'b1;
        end
        if (m_s2[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_level[c]   = m_s2[c];
            m_press[c]   = m_s2[c];
            m_release[c] = ~m_s2[c];
            m_run[c]     = 0;
            if (m_s2[c]) m_hold[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = button_raw;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    button_raw = '0;
    repeat (3) tick();
    checks++;
    if ({button_level, button_press, button_release, button_long} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {button_level, button_press, button_release, button_long});
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_press();
    logic [2:0] got, exp;
    button_raw = 2'b01;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      exp = {(t >= LAT), (t == LAT), 1'b0};
      got = {button_level[0], button_press[0], button_release[0]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL press t=%0d lvl/prs/rel got=%b exp=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] got, exp;
    button_raw = 2'b00;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      exp = {(t < LAT), 1'b0, (t == LAT)};
      got = {button_level[0], button_press[0], button_release[0]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL release t=%0d lvl/prs/rel got=%b exp=%b", t, got, exp);
      end
    end
    button_raw = 2'b01;
    repeat (10) tick();
    button_raw = 2'b00;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 2) button_raw = 2'b01;
      checks++;
      if ({button_level[0], button_release[0]} !== 2'b10) begin
        failures++;
        $display("FAIL release_bounce t=%0d lvl/rel got=%b exp=10", t, {button_level[0], button_release[0]});
      end
    end
    button_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    logic [1:0] got, exp;
    button_raw = 2'b01;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 3) button_raw = 2'b00;
      checks++;
      if ({button_level[0], button_press[0]} !== 2'b00) begin
        failures++;
        $display("FAIL glitch t=%0d lvl/prs got=%b exp=00", t, {button_level[0], button_press[0]});
      end
    end
    button_raw = 2'b01;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      exp = {(t >= LAT), (t == LAT)};
      got = {button_level[0], button_press[0]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL glitch_then_hold t=%0d lvl/prs got=%b exp=%b", t, got, exp);
      end
    end
    button_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    logic [3*N-1:0] got, exp;
    button_raw = 2'b11;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      exp = {((t >= LAT) ? 2'b11 : 2'b00), ((t == LAT) ? 2'b11 : 2'b00), 2'b00};
      got = {button_level, button_press, button_release};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL simul_press t=%0d lvl/prs/rel got=%b exp=%b", t, got, exp);
      end
    end
    button_raw = 2'b01;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      exp = {((t >= LAT) ? 2'b01 : 2'b11), 2'b00, ((t == LAT) ? 2'b10 : 2'b00)};
      got = {button_level, button_press, button_release};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL simul_release1 t=%0d lvl/prs/rel got=%b exp=%b", t, got, exp);
      end
    end
    button_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    logic [3*N-1:0] got, exp;
    button_raw = 2'b10;
    repeat (10) tick();
    button_raw = 2'b11;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({button_level, button_press, button_release, button_long} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=0", {button_level, button_press, button_release, button_long});
    end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      exp = {((t >= LAT) ? 2'b11 : 2'b00), ((t == LAT) ? 2'b11 : 2'b00), 2'b00};
      got = {button_level, button_press, button_release};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_mid_repress t=%0d lvl/prs/rel got=%b exp=%b", t, got, exp);
      end
    end
    button_raw = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_long_press();
    int pulses    = 0;
    int first_t   = -1;
    int other_ch  = 0;
    int exp_puls  = LONG_EN ? 1 : 0;
    int exp_first = LONG_EN ? (LAT + L) : -1;
    button_raw = 2'b01;
    for (int t = 1; t <= LAT + L + 15; t++) begin
      tick();
      if (button_long[0]) begin
        pulses++;
        if (first_t < 0) first_t = t;
      end
      if (button_long[1]) other_ch++;
    end
    button_raw = 2'b00;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (button_long[0]) pulses++;
    end
    checks++;
    if (pulses !== exp_puls) begin
      failures++;
      $display("FAIL long_count got=%0d exp=%0d", pulses, exp_puls);
    end
    checks++;
    if (first_t !== exp_first) begin
      failures++;
      $display("FAIL long_position got=%0d exp=%0d", first_t, exp_first);
    end
    checks++;
    if (other_ch !== 0) begin
      failures++;
      $display("FAIL long_other_channel got=%0d exp=0", other_ch);
    end
  endtask

  task automatic test_random();
    int hold [N];
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          button_raw[c] = ~button_raw[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(D, 35) : $urandom_range(1, D + 1);
        end
        hold[c]--;
      end
      reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({button_level, button_press, button_release, button_long} !== {m_level, m_press, m_release, m_long}) begin
        failures++;
        $display("FAIL random i=%0d lvl/prs/rel/long got=%b exp=%b", i,
                 {button_level, button_press, button_release, button_long},
                 {m_level, m_press, m_release, m_long});
      end
      checks++;
      if ((button_press & button_release) !== '0) begin
        failures++;
        $display("FAIL random_exclusive i=%0d prs&rel got=%b exp=0", i, button_press & button_release);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_long_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
